// File: rtl/qkd_pkg.sv
// Shared QKD definitions: the 3-bit detector/transmitter state codes and the
// capture-memory packing constants used by both ends of the link.
package qkd_pkg;

  localparam int CODE_W         = 3;
  localparam int CODES_PER_WORD = 10;
  localparam int PACK_W         = CODE_W * (CODES_PER_WORD - 1);
  localparam int BANK_WORDS     = 16384;

  localparam logic [CODE_W-1:0] ST_NONE  = 3'd0;
  localparam logic [CODE_W-1:0] ST_CH0   = 3'd1;
  localparam logic [CODE_W-1:0] ST_CH1   = 3'd2;
  localparam logic [CODE_W-1:0] ST_CH2   = 3'd3;
  localparam logic [CODE_W-1:0] ST_CH3   = 3'd4;
  localparam logic [CODE_W-1:0] ST_CH4   = 3'd5;
  localparam logic [CODE_W-1:0] ST_CH5   = 3'd6;
  localparam logic [CODE_W-1:0] ST_MULTI = 3'd7;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DATA_WR = 2'd1,
    MARK    = 2'd2
  } log_state_e;

endpackage

// File: rtl/detection_logger_if.sv
// Capture-memory write port plus the bank handshake seen by the SD/host copy engine.
interface detection_logger_if #(
  parameter int ADDR_W = 15
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              bank_sel;
  logic [31:0]       bank_count;

  modport master (output wr_en, wr_addr, wr_data, bank_sel, bank_count);
  modport slave  (input  wr_en, wr_addr, wr_data, bank_sel, bank_count);
endinterface

// File: rtl/detection_logger_state_decode.sv
// Combinational decode of the six detector click lines into a state code;
// anything other than zero or exactly one click is a multi-click.
module state_decode
  import qkd_pkg::*;
(
  input  logic [5:0]        pulses,
  output logic [CODE_W-1:0] code,
  output logic              multi
);

  always_comb begin
    code  = ST_MULTI;
    multi = 1'b1;
    case (pulses)
      6'h00: begin code = ST_NONE; multi = 1'b0; end
      6'h01: begin code = ST_CH0;  multi = 1'b0; end
      6'h02: begin code = ST_CH1;  multi = 1'b0; end
      6'h04: begin code = ST_CH2;  multi = 1'b0; end
      6'h08: begin code = ST_CH3;  multi = 1'b0; end
      6'h10: begin code = ST_CH4;  multi = 1'b0; end
      6'h20: begin code = ST_CH5;  multi = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/detection_logger.sv
// Receiver capture path: decodes detection slots, packs ten codes per word and
// writes them into a two-bank capture memory with a bank-count marker per bank.
module detection_logger
  import qkd_pkg::*;
#(
  parameter int ADDR_W = $clog2(2 * BANK_WORDS),
  parameter int MCNT_W = 16
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                slot_valid,
  input  logic [5:0]          pulses_in,
  output logic [CODE_W-1:0]   state_out,
  output logic                state_valid,
  detection_logger_if.master  mem,
  output logic [MCNT_W-1:0]   multi_count
);

  localparam logic [3:0]        LAST_IDX    = 4'(CODES_PER_WORD - 1);
  localparam logic [ADDR_W-2:0] BANK_END_M1 = {{(ADDR_W-2){1'b1}}, 1'b0};

  function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CODE_W-1:0] code;
  logic              multi;
  logic              accept;

  log_state_e        state_r, state_d;
  logic [ADDR_W-1:0] addr_r, addr_d;
  logic [3:0]        idx_r, idx_d;
  logic [PACK_W-1:0] pack_r, pack_d;
  logic [31:0]       word_r, word_d;
  logic [31:0]       mark_r;
  logic [31:0]       bank_count_r;
  logic              bank_sel_r;
  logic [MCNT_W-1:0] multi_r, multi_d;
  logic              word_done;
  logic              bank_end_m1;
  logic              enter_mark;
  logic              wr_en;

  state_decode u_decode (
    .pulses (pulses_in),
    .code   (code),
    .multi  (multi)
  );

  assign accept = slot_valid & enable;

  // Packer: codes 0..8 accumulate in pack_r; the 10th closes the word directly.
  always_comb begin
    idx_d     = idx_r;
    pack_d    = pack_r;
    word_d    = word_r;
    word_done = 1'b0;
    multi_d   = multi_r;
    if (accept) begin
      if (multi) multi_d = sat_inc(multi_r);
      if (idx_r == LAST_IDX) begin
        word_d    = {2'b00, code, pack_r};
        pack_d    = '0;
        idx_d     = '0;
        word_done = 1'b1;
      end else begin
        for (int k = 0; k < CODES_PER_WORD - 1; k++) begin
          if (idx_r == 4'(k)) pack_d[CODE_W*k +: CODE_W] = code;
        end
        idx_d = idx_r + 4'd1;
      end
    end
  end

  assign bank_end_m1 = (addr_r[ADDR_W-2:0] == BANK_END_M1);
  assign enter_mark  = (state_r == DATA_WR) && bank_end_m1;
  assign wr_en       = (state_r != COLLECT);
  assign addr_d      = wr_en ? addr_r + 1'b1 : addr_r;

  always_comb begin
    state_d = state_r;
    case (state_r)
      COLLECT: if (word_done) state_d = DATA_WR;
      DATA_WR: state_d = bank_end_m1 ? MARK : COLLECT;
      MARK:    state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    mem.wr_en      = wr_en;
    mem.wr_addr    = wr_en ? addr_r : '0;
    mem.bank_sel   = bank_sel_r;
    mem.bank_count = bank_count_r;
    case (state_r)
      DATA_WR: mem.wr_data = word_r;
      MARK:    mem.wr_data = mark_r;
      default: mem.wr_data = '0;
    endcase
  end

  assign multi_count = multi_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= COLLECT;
      addr_r       <= '0;
      idx_r        <= '0;
      pack_r       <= '0;
      word_r       <= '0;
      mark_r       <= '0;
      bank_sel_r   <= 1'b0;
      bank_count_r <= '0;
      multi_r      <= '0;
      state_out    <= '0;
      state_valid  <= 1'b0;
    end else begin
      state_r     <= state_d;
      addr_r      <= addr_d;
      idx_r       <= idx_d;
      pack_r      <= pack_d;
      word_r      <= word_d;
      multi_r     <= multi_d;
      state_valid <= accept;
      if (accept) state_out <= code;
      // Marker data latches the pre-increment count as the bank flag flips.
      if (enter_mark) begin
        mark_r       <= bank_count_r;
        bank_sel_r   <= ~bank_sel_r;
        bank_count_r <= bank_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_detection_logger.sv
// Directed bench for detection_logger: decode, packing, bank markers, wrap,
// enable gating, reset and multi-click saturation.
module tb_detection_logger;
  import qkd_pkg::*;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        enable     = 1'b0;
  logic        slot_valid = 1'b0;
  logic [5:0]  pulses_in  = 6'h00;
  logic [2:0]  state_out;
  logic        state_valid;
  logic [15:0] multi_count;

  int tests     = 0;
  int fails     = 0;
  int wr_cnt    = 0;
  int wr_before = 0;
  logic sv_prev = 1'b0;
  logic [5:0] mp [4];

  detection_logger_if #(.ADDR_W(15)) bus ();

  detection_logger #(.ADDR_W(15), .MCNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .slot_valid  (slot_valid),
    .pulses_in   (pulses_in),
    .state_out   (state_out),
    .state_valid (state_valid),
    .mem         (bus),
    .multi_count (multi_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_en) wr_cnt <= wr_cnt + 1;
    if (slot_valid && sv_prev) begin
      fails++;
      $display("FAIL slot_valid_protocol consecutive strobes at %0t", $time);
    end
    sv_prev <= slot_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic [5:0] p);
    @(negedge clk);
    slot_valid = 1'b1;
    pulses_in  = p;
    @(negedge clk);
    slot_valid = 1'b0;
    pulses_in  = 6'h00;
  endtask

  task automatic slot_chk(input logic [5:0] p, input logic [2:0] code);
    slot(p);
    chk("state_valid", 32'(state_valid), 32'd1);
    chk("state_out", 32'(state_out), 32'(code));
  endtask

  task automatic word(input logic [5:0] p, input logic [2:0] code,
                      input logic [14:0] addr, input logic [31:0] data);
    for (int i = 0; i < 10; i++) slot_chk(p, code);
    chk("word_wr_en", 32'(bus.wr_en), 32'd1);
    chk("word_wr_addr", 32'(bus.wr_addr), 32'(addr));
    chk("word_wr_data", bus.wr_data, data);
  endtask

  initial begin
    mp[0] = 6'h3F; mp[1] = 6'h03; mp[2] = 6'h30; mp[3] = 6'h21;

    // reset held mid-word
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    slot_chk(6'h03, 3'd7);
    slot_chk(6'h01, 3'd1);
    slot_chk(6'h02, 3'd2);
    chk("pre_reset_multi", 32'(multi_count), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_state_out", 32'(state_out), 32'd0);
    chk("rst_state_valid", 32'(state_valid), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_bank_sel", 32'(bus.bank_sel), 32'd0);
    chk("rst_bank_count", bus.bank_count, 32'd0);
    chk("rst_multi", 32'(multi_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // decode and pack, first word at address 0
    slot_chk(6'h01, 3'd1);
    slot_chk(6'h02, 3'd2);
    slot_chk(6'h04, 3'd3);
    slot_chk(6'h08, 3'd4);
    slot_chk(6'h10, 3'd5);
    slot_chk(6'h20, 3'd6);
    slot_chk(6'h00, 3'd0);
    slot_chk(6'h03, 3'd7);
    slot_chk(6'h20, 3'd6);
    slot_chk(6'h01, 3'd1);
    chk("dec_wr_en", 32'(bus.wr_en), 32'd1);
    chk("dec_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("dec_wr_data", bus.wr_data, 32'h0EE358D1);
    chk("dec_multi", 32'(multi_count), 32'd1);
    @(negedge clk);
    chk("dec_no_marker", 32'(bus.wr_en), 32'd0);
    chk("dec_valid_drop", 32'(state_valid), 32'd0);
    wr_before = wr_cnt;

    // enable gating
    slot_chk(6'h01, 3'd1);
    slot_chk(6'h02, 3'd2);
    slot_chk(6'h04, 3'd3);
    slot_chk(6'h08, 3'd4);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      slot(6'h20);
      chk("gated_valid", 32'(state_valid), 32'd0);
      chk("gated_wr_en", 32'(bus.wr_en), 32'd0);
    end
    enable = 1'b1;
    slot_chk(6'h10, 3'd5);
    slot_chk(6'h20, 3'd6);
    slot_chk(6'h00, 3'd0);
    slot_chk(6'h01, 3'd1);
    slot_chk(6'h02, 3'd2);
    slot_chk(6'h04, 3'd3);
    chk("gate_wr_en", 32'(bus.wr_en), 32'd1);
    chk("gate_wr_addr", 32'(bus.wr_addr), 32'd1);
    chk("gate_wr_data", bus.wr_data, 32'h1A2358D1);
    @(negedge clk);
    chk("gate_no_marker", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    chk("gate_write_count", 32'(wr_cnt - wr_before), 32'd1);

    // first bank boundary
    @(negedge clk);
    force dut.addr_r = 15'd16382;
    @(negedge clk);
    release dut.addr_r;
    word(6'h01, 3'd1, 15'd16382, 32'h09249249);
    chk("b0_bank_sel_before", 32'(bus.bank_sel), 32'd0);
    @(negedge clk);
    chk("b0_mark_wr_en", 32'(bus.wr_en), 32'd1);
    chk("b0_mark_addr", 32'(bus.wr_addr), 32'd16383);
    chk("b0_mark_data", bus.wr_data, 32'd0);
    chk("b0_bank_sel", 32'(bus.bank_sel), 32'd1);
    chk("b0_bank_count", bus.bank_count, 32'd1);
    @(negedge clk);
    chk("b0_after_mark", 32'(bus.wr_en), 32'd0);
    word(6'h00, 3'd0, 15'd16384, 32'h00000000);
    @(negedge clk);

    // second bank boundary and address wrap
    force dut.addr_r = 15'd32766;
    @(negedge clk);
    release dut.addr_r;
    word(6'h02, 3'd2, 15'd32766, 32'h12492492);
    @(negedge clk);
    chk("b1_mark_wr_en", 32'(bus.wr_en), 32'd1);
    chk("b1_mark_addr", 32'(bus.wr_addr), 32'd32767);
    chk("b1_mark_data", bus.wr_data, 32'd1);
    chk("b1_bank_sel", 32'(bus.bank_sel), 32'd0);
    chk("b1_bank_count", bus.bank_count, 32'd2);
    @(negedge clk);
    chk("b1_after_mark", 32'(bus.wr_en), 32'd0);
    word(6'h04, 3'd3, 15'd0, 32'h1B6DB6DB);
    @(negedge clk);

    // multi-click saturation, count preloaded near the top
    force dut.multi_r = 16'hFFF0;
    @(negedge clk);
    release dut.multi_r;
    for (int i = 1; i <= 19; i++) begin
      slot_chk(mp[i % 4], 3'd7);
      chk("sat_multi", 32'(multi_count), (i < 15) ? 32'hFFF0 + 32'(i) : 32'h0000FFFF);
      if (i == 10) begin
        chk("sat_wr_en", 32'(bus.wr_en), 32'd1);
        chk("sat_wr_addr", 32'(bus.wr_addr), 32'd1);
        chk("sat_wr_data", bus.wr_data, 32'h3FFFFFFF);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/detection_logger.md
# detection_logger

Receiver-side counterpart of the transmitter's state pulse generator. Each detection slot, it decodes the six one-hot detector click lines into the same 3-bit state code the transmitter uses, then packs ten codes per 32-bit word. Words are written to a two-bank (2 × 16384 word) capture memory. The last address of each bank holds a running bank-count marker, and the block toggles a bank-select flag so the SD/host copy engine can drain the full bank.

## Interface
Parameters:
- `ADDR_W`, 15: capture memory address width (2 banks × 2^(ADDR_W-1) words)
- `MCNT_W`, 16: multi-click counter width

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  capture enable; when low, `slot_valid` is ignored and the partial word is held
- `slot_valid`  in  1  one-cycle strobe marking the sampling cycle of a detection slot; at most every other cycle
- `pulses_in`  in  6  detector clicks, already synchronised; bit i = channel i
- `state_out`  out  3  last decoded state code
- `state_valid`  out  1  one-cycle strobe qualifying `state_out`
- `wr_data`  out  32  memory write data
- `wr_addr`  out  ADDR_W  memory write address
- `wr_en`  out  1  one-cycle memory write strobe
- `bank_sel`  out  1  toggles when a bank is completed (copy-engine trigger)
- `bank_count`  out  32  number of completed banks
- `multi_count`  out  MCNT_W  saturating count of multi-click slots

## Operation
Decode, evaluated only on `slot_valid & enable`:
- exactly bit i set → code i+1 (001…110)
- `pulses_in == 0` → 000 (no click)
- two or more bits set → 111 (multi-click); `multi_count` += 1, saturating at all-ones

Packing:
- Code k (k = 0..9) goes to `word[3k+2:3k]`; `word[31:30]` = 00.
- A 4-bit slot index counts 0..9. On the 10th code the completed word is issued and the index returns to 0.
- Codes accepted after completion start a fresh word, so no slot is lost.

Address and bank control:
- Each data write uses the current `wr_addr`; the address increments after the write.
- A data write to address 2^(ADDR_W-1)−2 or 2^ADDR_W−2 (16382 or 32766) is followed on the next cycle by a marker write:
  - `wr_data = bank_count`, address 16383 or 32767 respectively
  - `bank_sel` toggles and `bank_count` += 1 in the marker-write cycle
  - the address then advances; 32767 wraps to 0
- State machine:
  - COLLECT: default state.
  - COLLECT → DATA_WR on word completion.
  - DATA_WR → MARK if the write address is a bank-end−1 address, else DATA_WR → COLLECT.
  - MARK → COLLECT unconditionally.
- Decode and packing continue in every state.

## Timing
- Reset (async assert; release synchronous to `clk`): all outputs 0, address 0, slot index 0, pack register 0, state COLLECT.
- `state_out`/`state_valid`: registered, 1 cycle after `slot_valid`.
- Data write: `wr_en` high for 1 cycle, the cycle after the 10th accepted `slot_valid`. `wr_data` and `wr_addr` are valid only while `wr_en` is high.
- Marker write: 1 cycle after the data write. Back-to-back `wr_en` is allowed only here.
- `slot_valid` in a DATA_WR or MARK cycle is accepted normally into the new word.
- `enable` falling mid-word: the partial word and slot index are held; packing resumes on re-enable. No flush.
- Reset mid-word or mid-marker: the partial word is discarded, no write is issued, and `bank_count` clears.
- `slot_valid` on consecutive cycles is a protocol violation; the bench flags it and behaviour is undefined.

## Structure
- Shared package `qkd_pkg`:
  - state code constants `ST_NONE`=000 … `ST_MULTI`=111
  - `CODES_PER_WORD` = 10, `CODE_W` = 3
  - bank-size constant
- The transmitter uses the same codes; the package is the single source.
- Sub-module `state_decode`: combinational 6-bit one-hot → 3-bit code plus `multi` flag. Everything else (packer, address/bank FSM, counters) stays in `detection_logger`.

## Test plan
- Reset: hold `rst` low mid-word → all outputs 0. After release, the first word lands at address 0.
- Decode/pack: ten slots, every other cycle, with `pulses_in` = 01, 02, 04, 08, 10, 20, 00, 03, 20, 01 (hex) → `state_out` sequence 1,2,3,4,5,6,0,7,6,1. Then `wr_en` at address 0 with `wr_data` = 0x0EE358D1, and `multi_count` = 1.
- Bank boundary: preload address to 16382 and complete a word → data write at 16382, then marker write 0x00000000 at 16383 on the next cycle. `bank_sel` 0→1, `bank_count` = 1, next data write at 16384.
- Wrap: complete a word at 32766 → marker at 32767 with `wr_data` = current `bank_count`, `bank_sel` toggles back, next write at address 0.
- Enable gating: drop `enable` after 4 slots, pulse `slot_valid` 5 times, re-enable, 6 more slots → exactly one write, containing the 4 + 6 enabled codes in order.
- Saturation: 2^16+3 multi-click slots → `multi_count` = 0xFFFF; each of those slots decodes to code 7.
